// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 3;
  localparam logic [ADDR_W-1:0] RO_ADDR = 3'd7;

  // Owner index width; two clients need a single bit.
  localparam int OWNER_W = 1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef struct packed {
    logic [OWNER_W-1:0] owner;
    op_t                op;
    logic               err;
    logic               valid;
  } issue_t;

endpackage

// File: rtl/regfile_port_arbiter_rr.sv
// Two-client grant logic for the register-file port arbiter.
// ROUND_ROBIN_EN selects alternating priority; otherwise client 0 always wins.
module rr_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   advance,
  output logic [NUM_CLIENTS-1:0] grant
);

`ifdef ROUND_ROBIN_EN
  // 1 = client 1 is preferred on a tie (client 0 won the last handshake).
  logic prefer_1;

  // Tie goes to the client that did not win the most recent handshake.
  always_comb begin
    grant    = '0;
    grant[0] = req[0] & (~req[1] | ~prefer_1);
    grant[1] = req[1] & (~req[0] | prefer_1);
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_1 <= 1'b0;
    end else if (advance) begin
      prefer_1 <= grant[0];
    end
  end
`else
  // Fixed priority: client 0 first; no pointer state is kept.
  always_comb begin
    grant    = '0;
    grant[0] = req[0];
    grant[1] = req[1] & ~req[0];
  end

  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file access path (two read ports, one write port)
// between two clients. Two-stage pipeline: issue register drives the register
// file, completion register returns results to the owning client.
// Build option: ROUND_ROBIN_EN (round-robin grant instead of fixed priority).
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = regfile_arb_pkg::NUM_CLIENTS,
  parameter int DATA_W      = regfile_arb_pkg::DATA_W,
  parameter int ADDR_W      = regfile_arb_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RO_ADDR = regfile_arb_pkg::RO_ADDR
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CLIENTS-1:0]             req_valid,
  output logic [NUM_CLIENTS-1:0]             req_ready,
  input  logic [NUM_CLIENTS-1:0]             req_write,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] req_addr_a,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] req_addr_b,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]             rsp_valid,
  output logic                               rsp_err,
  output logic [DATA_W-1:0]                  rsp_data_a,
  output logic [DATA_W-1:0]                  rsp_data_b,
  output logic [ADDR_W-1:0]                  rf_a1,
  output logic [ADDR_W-1:0]                  rf_a2,
  output logic [ADDR_W-1:0]                  rf_a3,
  output logic                               rf_we,
  output logic [DATA_W-1:0]                  rf_wd,
  input  logic [DATA_W-1:0]                  rf_rd1,
  input  logic [DATA_W-1:0]                  rf_rd2
);

  logic [NUM_CLIENTS-1:0] grant;
  logic                   accept;
  logic                   sel;
  logic                   sel_write;
  logic                   sel_ro;
  logic                   s2_read;
  issue_t                 s1;
  issue_t                 s2;

  rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel       = grant[1];
  assign sel_write = req_write[sel];
  assign sel_ro    = (req_addr_a[sel] == RO_ADDR);

  // Issue stage: load register-file controls on accept; addresses hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      rf_a1 <= '0;
      rf_a2 <= '0;
      rf_a3 <= '0;
      rf_wd <= '0;
      rf_we <= 1'b0;
    end else begin
      s1.valid <= accept;
      rf_we    <= 1'b0;
      if (accept) begin
        s1.owner <= sel;
        s1.op    <= sel_write ? OP_WRITE : OP_READ;
        s1.err   <= sel_write & sel_ro;
        if (sel_write) begin
          rf_a3 <= req_addr_a[sel];
          rf_wd <= req_wdata[sel];
          rf_we <= ~sel_ro;
        end else begin
          rf_a1 <= req_addr_a[sel];
          rf_a2 <= req_addr_b[sel];
        end
      end
    end
  end

  // Completion stage: aligns with the register file's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2 <= '0;
    end else begin
      s2 <= s1;
    end
  end

  // Route the completion to its owner; data is zero unless it was a read.
  always_comb begin
    rsp_valid           = '0;
    rsp_valid[s2.owner] = s2.valid;
    rsp_err             = s2.valid & s2.err;
    s2_read             = s2.valid & (s2.op == OP_READ);
    rsp_data_a          = s2_read ? rf_rd1 : '0;
    rsp_data_b          = s2_read ? rf_rd2 : '0;
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [1:0][2:0] req_addr_a;
  logic [1:0][2:0] req_addr_b;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic            rsp_err;
  logic [7:0]      rsp_data_a;
  logic [7:0]      rsp_data_b;
  logic [2:0]      rf_a1, rf_a2, rf_a3;
  logic            rf_we;
  logic [7:0]      rf_wd;
  logic [7:0]      rf_rd1, rf_rd2;

  regfile_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rf_a1      (rf_a1),
    .rf_a2      (rf_a2),
    .rf_a3      (rf_a3),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: registered reads, R7 driven externally, R7 not writable.
  logic [7:0] mem [0:7];
  logic [7:0] r7_val;
  always @(posedge clk) begin
    rf_rd1 <= (rf_a1 == 3'd7) ? r7_val : mem[rf_a1];
    rf_rd2 <= (rf_a2 == 3'd7) ? r7_val : mem[rf_a2];
    if (rf_we && rf_a3 != 3'd7) mem[rf_a3] <= rf_wd;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         owner;
    bit         err;
    logic [7:0] da;
    logic [7:0] db;
  } exp_t;

  exp_t       q[$];
  logic [7:0] shadow [0:7];
  int         last_grant;
  int         iter;
  int         total;
  int         bad;
  int         rsp_cnt;
  int         last_acc_owner;
  logic [1:0] dut_ready_seen;
  logic       exp_we;
  logic [2:0] exp_a1, exp_a2, exp_a3;
  logic [7:0] exp_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, iter);
    end
  endtask

  function automatic logic [7:0] rd_val(input logic [2:0] a);
    return (a == 3'd7) ? r7_val : shadow[a];
  endfunction

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ROUND_ROBIN_EN
      return (last_grant == 0) ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  // One clock: check grant, advance the model, then compare registered outputs.
  task automatic cycle();
    logic [1:0] eg;
    exp_t       e;
    int         o;
    #1;
    eg = model_grant(req_valid);
    dut_ready_seen = req_ready;
    chk("req_ready", {30'd0, req_ready}, {30'd0, eg});
    last_acc_owner = -1;
    exp_we = 1'b0;
    if (!reset && eg != 2'b00) begin
      o = eg[1] ? 1 : 0;
      last_grant = o;
      last_acc_owner = o;
      e.due   = iter + 2;
      e.owner = o;
      e.err   = req_write[o] && (req_addr_a[o] == 3'd7);
      if (req_write[o]) begin
        e.da = 8'h00;
        e.db = 8'h00;
        exp_a3 = req_addr_a[o];
        exp_wd = req_wdata[o];
        exp_we = !e.err;
        if (!e.err) shadow[req_addr_a[o]] = req_wdata[o];
      end else begin
        e.da = rd_val(req_addr_a[o]);
        e.db = rd_val(req_addr_b[o]);
        exp_a1 = req_addr_a[o];
        exp_a2 = req_addr_b[o];
      end
      q.push_back(e);
    end
    if (reset) begin
      q.delete();
      last_grant = -1;
      exp_we = 1'b0;
      exp_a1 = '0; exp_a2 = '0; exp_a3 = '0; exp_wd = '0;
    end
    @(negedge clk);
    iter++;
    if (rsp_valid != 2'b00) rsp_cnt++;
    if (q.size() > 0 && q[0].due == iter) begin
      e = q.pop_front();
      chk("rsp_valid", {30'd0, rsp_valid}, (e.owner == 1) ? 32'd2 : 32'd1);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      chk("rsp_data_a", {24'd0, rsp_data_a}, {24'd0, e.da});
      chk("rsp_data_b", {24'd0, rsp_data_b}, {24'd0, e.db});
    end else begin
      chk("rsp_valid_idle", {30'd0, rsp_valid}, 32'd0);
      chk("rsp_err_idle", {31'd0, rsp_err}, 32'd0);
    end
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    chk("rf_a1", {29'd0, rf_a1}, {29'd0, exp_a1});
    chk("rf_a2", {29'd0, rf_a2}, {29'd0, exp_a2});
    chk("rf_a3", {29'd0, rf_a3}, {29'd0, exp_a3});
    chk("rf_wd", {24'd0, rf_wd}, {24'd0, exp_wd});
  endtask

  task automatic set_req(input int c, input bit wr, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] wd);
    req_valid[c]  = 1'b1;
    req_write[c]  = wr;
    req_addr_a[c] = a;
    req_addr_b[c] = b;
    req_wdata[c]  = wd;
  endtask

  task automatic idle(input int c);
    req_valid[c] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] gr_log [0:5];
  logic [1:0] gr_exp [0:5];
  int         snap;

  initial begin
    total = 0; bad = 0; iter = 0; rsp_cnt = 0;
    last_grant = -1; last_acc_owner = -1;
    exp_we = 1'b0; exp_a1 = '0; exp_a2 = '0; exp_a3 = '0; exp_wd = '0;
    r7_val = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      mem[i]    = 8'(i * 17);
      shadow[i] = 8'(i * 17);
    end
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr_a = '0; req_addr_b = '0; req_wdata = '0;

    // Reset for two cycles: everything idle and zero.
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_data_a", {24'd0, rsp_data_a}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_addr", {23'd0, rf_a1, rf_a2, rf_a3}, 32'd0);
    chk("rst_rf_wd", {24'd0, rf_wd}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);

    // Write to R7 right after release is rejected.
    set_req(0, 1'b1, 3'd7, 3'd0, 8'h5A);
    cycle(); idle(0);
    chk("r7w0_rf_we", {31'd0, rf_we}, 32'd0);
    cycle();
    chk("r7w0_valid", {30'd0, rsp_valid}, 32'd1);
    chk("r7w0_err", {31'd0, rsp_err}, 32'd1);

    // Client 0 writes R3=A5, client 1 reads (3,7) the very next cycle.
    set_req(0, 1'b1, 3'd3, 3'd0, 8'hA5);
    cycle(); idle(0);
    set_req(1, 1'b0, 3'd3, 3'd7, 8'h00);
    cycle(); idle(1);
    cycle();
    chk("raw_valid", {30'd0, rsp_valid}, 32'd2);
    chk("raw_data_a", {24'd0, rsp_data_a}, 32'hA5);
    chk("raw_data_b", {24'd0, rsp_data_b}, 32'h3C);

    // Client 1 writes R7=FF, then reads R7 back.
    set_req(1, 1'b1, 3'd7, 3'd0, 8'hFF);
    cycle(); idle(1);
    chk("r7w1_rf_we", {31'd0, rf_we}, 32'd0);
    cycle();
    chk("r7w1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("r7w1_err", {31'd0, rsp_err}, 32'd1);
    set_req(1, 1'b0, 3'd7, 3'd7, 8'h00);
    cycle(); idle(1);
    cycle();
    chk("r7_read", {24'd0, rsp_data_a}, 32'h3C);

    // Both clients contend for six cycles from a fresh reset.
    reset = 1'b1; cycle(); reset = 1'b0;
    set_req(0, 1'b0, 3'd1, 3'd2, 8'h00);
    set_req(1, 1'b0, 3'd3, 3'd4, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cycle();
      gr_log[i] = dut_ready_seen;
`ifdef ROUND_ROBIN_EN
      gr_exp[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      gr_exp[i] = 2'b01;
`endif
    end
    idle(0); idle(1);
    for (int i = 0; i < 6; i++) chk("contend_grant", {30'd0, gr_log[i]}, {30'd0, gr_exp[i]});
    cycle(); cycle();

    // Eight back-to-back reads: eight consecutive completions.
    snap = rsp_cnt;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b0, 3'(i), 3'(7 - i), 8'h00);
      cycle();
    end
    idle(0);
    cycle(); cycle();
    chk("b2b_count", rsp_cnt - snap, 32'd8);

    // Reset the cycle after a read is accepted: that read never completes.
    set_req(0, 1'b0, 3'd2, 3'd5, 8'h00);
    cycle(); idle(0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_drop_valid", {30'd0, rsp_valid}, 32'd0);
    cycle();
    chk("rst_drop_valid2", {30'd0, rsp_valid}, 32'd0);
    set_req(1, 1'b0, 3'd4, 3'd1, 8'h00);
    cycle(); idle(1);
    cycle();
    chk("post_rst_valid", {30'd0, rsp_valid}, 32'd2);
    chk("post_rst_data_a", {24'd0, rsp_data_a}, 32'h44);
    chk("post_rst_data_b", {24'd0, rsp_data_b}, 32'h11);

    // Randomized traffic; a loser keeps its request until granted.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req_valid[c] && $urandom_range(0, 99) < 65)
          set_req(c, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
      cycle();
      if (last_acc_owner >= 0) idle(last_acc_owner);
    end
    idle(0); idle(1);
    cycle(); cycle(); cycle();
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
